// File: rtl/ctrl_br_pkg.sv
// Shared types for the register-bank controller: FSM states, command opcodes and bus widths.
package ctrl_br_pkg;

  localparam int ANCHO_DATO = 8;
  localparam int ANCHO_DIR  = 2;

  localparam logic [1:0] OP_ESCRIBE    = 2'b00;
  localparam logic [1:0] OP_LEE        = 2'b01;
  localparam logic [1:0] OP_LIMPIA     = 2'b10;
  localparam logic [1:0] OP_INCREMENTA = 2'b11;

  typedef enum logic [2:0] {
    REPOSO,
    ESCRIBE,
    LEE,
    CAPTURA,
    SUMA,
    LIMPIA,
    RESP
  } estado_t;

endpackage

// File: rtl/banco_br.sv
// 4x8 register bank: writes and reads sampled on the rising edge; Dato_s holds between reads.
// No reset, so contents survive a controller reset.
module banco_br
  import ctrl_br_pkg::*;
(
  input  logic                  clk,
  input  logic                  En,
  input  logic                  WE,
  input  logic [ANCHO_DIR-1:0]  Dir,
  input  logic [ANCHO_DATO-1:0] Dato_e,
  output logic [ANCHO_DATO-1:0] Dato_s
);

  logic [ANCHO_DATO-1:0] regs [4];

  always_ff @(posedge clk) begin
    if (En && WE) begin
      regs[Dir] <= Dato_e;
    end
    if (En && !WE) begin
      Dato_s <= regs[Dir];
    end
  end

endmodule

// File: rtl/controlador_br.sv
// Command FSM in front of a 4x8 register bank; write 1 cycle, read response after 2, increment after 3, clear 4.
// One command at a time (cmd_ready only in REPOSO); a response is held until rsp_ready.
module controlador_br
  import ctrl_br_pkg::*;
(
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  cmd_valid,
  output logic                  cmd_ready,
  input  logic [1:0]            cmd_op,
  input  logic [ANCHO_DIR-1:0]  cmd_dir,
  input  logic [ANCHO_DATO-1:0] cmd_dato,
  output logic                  rsp_valid,
  input  logic                  rsp_ready,
  output logic [ANCHO_DATO-1:0] rsp_dato,
  output logic                  ocupado,
  output logic                  En_br,
  output logic                  WE_br,
  output logic [ANCHO_DIR-1:0]  Dir_br,
  output logic [ANCHO_DATO-1:0] Dato_e_br,
  input  logic [ANCHO_DATO-1:0] Dato_s_br
);

  estado_t               estado, estado_n;
  logic [1:0]            op_q, op_n;
  logic [ANCHO_DIR-1:0]  dir_q, dir_n;
  logic [ANCHO_DIR-1:0]  cnt, cnt_n;
  logic                  en_n, we_n, rsp_valid_n;
  logic [ANCHO_DIR-1:0]  dir_br_n;
  logic [ANCHO_DATO-1:0] dato_e_n, rsp_dato_n;

  // Decoded from the state register only, so no input reaches it combinationally.
  assign cmd_ready = (estado == REPOSO);

  always_ff @(posedge clk) begin
    if (rst) begin
      estado    <= REPOSO;
      op_q      <= OP_ESCRIBE;
      dir_q     <= '0;
      cnt       <= '0;
      En_br     <= 1'b0;
      WE_br     <= 1'b0;
      Dir_br    <= '0;
      Dato_e_br <= '0;
      rsp_valid <= 1'b0;
      rsp_dato  <= '0;
      ocupado   <= 1'b0;
    end else begin
      estado    <= estado_n;
      op_q      <= op_n;
      dir_q     <= dir_n;
      cnt       <= cnt_n;
      En_br     <= en_n;
      WE_br     <= we_n;
      Dir_br    <= dir_br_n;
      Dato_e_br <= dato_e_n;
      rsp_valid <= rsp_valid_n;
      rsp_dato  <= rsp_dato_n;
      ocupado   <= (estado_n != REPOSO);
    end
  end

  always_comb begin
    estado_n    = estado;
    op_n        = op_q;
    dir_n       = dir_q;
    cnt_n       = cnt;
    en_n        = 1'b0;
    we_n        = 1'b0;
    dir_br_n    = Dir_br;
    dato_e_n    = Dato_e_br;
    rsp_valid_n = rsp_valid;
    rsp_dato_n  = rsp_dato;

    case (estado)
      REPOSO: begin
        if (cmd_valid) begin
          op_n  = cmd_op;
          dir_n = cmd_dir;
          case (cmd_op)
            OP_ESCRIBE: begin
              estado_n = ESCRIBE;
              en_n     = 1'b1;
              we_n     = 1'b1;
              dir_br_n = cmd_dir;
              dato_e_n = cmd_dato;
            end
            OP_LIMPIA: begin
              estado_n = LIMPIA;
              en_n     = 1'b1;
              we_n     = 1'b1;
              dir_br_n = cnt;
              dato_e_n = '0;
              cnt_n    = cnt + 2'd1;
            end
            default: begin
              // LEE and INCREMENTA share the read phase.
              estado_n = LEE;
              en_n     = 1'b1;
              we_n     = 1'b0;
              dir_br_n = cmd_dir;
            end
          endcase
        end
      end
      ESCRIBE: estado_n = REPOSO;
      LEE:     estado_n = CAPTURA;
      CAPTURA: begin
        if (op_q == OP_INCREMENTA) begin
          estado_n = SUMA;
          en_n     = 1'b1;
          we_n     = 1'b1;
          dir_br_n = dir_q;
          dato_e_n = Dato_s_br + 8'd1;
        end else begin
          estado_n    = RESP;
          rsp_valid_n = 1'b1;
          rsp_dato_n  = Dato_s_br;
        end
      end
      SUMA: begin
        estado_n    = RESP;
        rsp_valid_n = 1'b1;
        rsp_dato_n  = Dato_e_br;
      end
      LIMPIA: begin
        // Dir_br is the register being cleared this cycle; 3 is the last one.
        if (Dir_br == 2'd3) begin
          estado_n = REPOSO;
          cnt_n    = '0;
        end else begin
          en_n     = 1'b1;
          we_n     = 1'b1;
          dir_br_n = cnt;
          dato_e_n = '0;
          cnt_n    = cnt + 2'd1;
        end
      end
      RESP: begin
        if (rsp_ready) begin
          estado_n    = REPOSO;
          rsp_valid_n = 1'b0;
        end
      end
      default: estado_n = REPOSO;
    endcase
  end

endmodule

// File: tb/tb_controlador_br.sv
// Directed bench: controller plus register bank, table of commands with hand-computed results and corner sequences.
module tb_controlador_br;
  import ctrl_br_pkg::*;

  logic       clk = 1'b0;
  logic       rst;
  logic       cmd_valid, cmd_ready, rsp_valid, rsp_ready, ocupado;
  logic [1:0] cmd_op, cmd_dir, Dir_br;
  logic [7:0] cmd_dato, rsp_dato, Dato_e_br, Dato_s_br;
  logic       En_br, WE_br;

  int checks   = 0;
  int failures = 0;
  int viol     = 0;

  typedef struct packed {
    logic [1:0] dir;
    logic [7:0] dato;
  } wr_t;
  wr_t wr_log[$];

  typedef struct {
    logic [1:0] op;
    logic [1:0] dir;
    logic [7:0] dato;
    int         lat;
    logic [7:0] rsp;
    int         nwr;
    logic [1:0] wdir;
    logic [7:0] wdato;
  } vec_t;
  vec_t tabla[$];

  controlador_br dut (
    .clk(clk), .rst(rst), .cmd_valid(cmd_valid), .cmd_ready(cmd_ready),
    .cmd_op(cmd_op), .cmd_dir(cmd_dir), .cmd_dato(cmd_dato),
    .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_dato(rsp_dato),
    .ocupado(ocupado), .En_br(En_br), .WE_br(WE_br), .Dir_br(Dir_br),
    .Dato_e_br(Dato_e_br), .Dato_s_br(Dato_s_br)
  );

  banco_br banco (
    .clk(clk), .En(En_br), .WE(WE_br), .Dir(Dir_br),
    .Dato_e(Dato_e_br), .Dato_s(Dato_s_br)
  );

  always #5 clk = ~clk;

  always @(negedge clk) begin
    if (En_br && WE_br) wr_log.push_back('{dir: Dir_br, dato: Dato_e_br});
    if (cmd_ready != !ocupado) viol++;
  end

  task automatic chk(input string nm, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h", nm, got, exp);
    end
  endtask

  function automatic vec_t mk(input logic [1:0] op, input logic [1:0] dir, input logic [7:0] dato,
                              input int lat, input logic [7:0] rsp, input int nwr,
                              input logic [1:0] wdir, input logic [7:0] wdato);
    vec_t v;
    v.op = op; v.dir = dir; v.dato = dato; v.lat = lat; v.rsp = rsp;
    v.nwr = nwr; v.wdir = wdir; v.wdato = wdato;
    return v;
  endfunction

  // Offer a command at a negedge; returns at the negedge just after the accepting edge.
  task automatic send(input logic [1:0] op, input logic [1:0] dir, input logic [7:0] dato);
    int n = 0;
    cmd_valid = 1'b1; cmd_op = op; cmd_dir = dir; cmd_dato = dato;
    while (!cmd_ready && n < 50) begin
      @(negedge clk);
      n++;
    end
    if (n >= 50) chk("accept_timeout", 32'(n), 32'd0);
    @(negedge clk);
    cmd_valid = 1'b0;
  endtask

  task automatic run(input string nm, input vec_t v);
    int  n = 0;
    logic es_rsp;
    es_rsp = (v.op == OP_LEE) || (v.op == OP_INCREMENTA);
    wr_log.delete();
    send(v.op, v.dir, v.dato);
    while (!(es_rsp ? rsp_valid : cmd_ready) && n < 40) begin
      @(negedge clk);
      n++;
    end
    chk({nm, "_lat"}, 32'(n), 32'(v.lat));
    chk({nm, "_nwr"}, 32'(wr_log.size()), 32'(v.nwr));
    if (v.op == OP_LIMPIA) begin
      for (int i = 0; i < wr_log.size() && i < 4; i++)
        chk($sformatf("%s_clr%0d", nm, i), {22'd0, wr_log[i].dir, wr_log[i].dato}, 32'(i) << 8);
    end else if (v.nwr == 1 && wr_log.size() == 1) begin
      chk({nm, "_wr"}, {22'd0, wr_log[0].dir, wr_log[0].dato}, {22'd0, v.wdir, v.wdato});
    end
    if (es_rsp) begin
      chk({nm, "_rsp"}, {24'd0, rsp_dato}, {24'd0, v.rsp});
      rsp_ready = 1'b1;
      @(negedge clk);
      rsp_ready = 1'b0;
      chk({nm, "_done"}, {30'd0, rsp_valid, cmd_ready}, 32'b01);
    end
  endtask

  initial begin
    int acc;
    logic [7:0] pat;
    rst = 1'b1; cmd_valid = 1'b0; cmd_op = 2'b00; cmd_dir = 2'b00;
    cmd_dato = 8'h00; rsp_ready = 1'b0;
    repeat (2) @(negedge clk);
    chk("reset_outs", {9'd0, En_br, WE_br, Dir_br, Dato_e_br, rsp_valid, rsp_dato, ocupado, cmd_ready},
        32'h0000_0001);
    rst = 1'b0;
    @(negedge clk);

    tabla.push_back(mk(OP_ESCRIBE,    2, 8'hA5, 1, 8'h00, 1, 2, 8'hA5));
    tabla.push_back(mk(OP_LEE,        2, 8'h00, 2, 8'hA5, 0, 0, 8'h00));
    tabla.push_back(mk(OP_ESCRIBE,    1, 8'hFF, 1, 8'h00, 1, 1, 8'hFF));
    tabla.push_back(mk(OP_INCREMENTA, 1, 8'h00, 3, 8'h00, 1, 1, 8'h00));
    tabla.push_back(mk(OP_LEE,        1, 8'h00, 2, 8'h00, 0, 0, 8'h00));
    tabla.push_back(mk(OP_ESCRIBE,    0, 8'h41, 1, 8'h00, 1, 0, 8'h41));
    tabla.push_back(mk(OP_INCREMENTA, 0, 8'h00, 3, 8'h42, 1, 0, 8'h42));
    tabla.push_back(mk(OP_LEE,        0, 8'h00, 2, 8'h42, 0, 0, 8'h00));
    tabla.push_back(mk(OP_ESCRIBE,    0, 8'h11, 1, 8'h00, 1, 0, 8'h11));
    tabla.push_back(mk(OP_ESCRIBE,    1, 8'h22, 1, 8'h00, 1, 1, 8'h22));
    tabla.push_back(mk(OP_ESCRIBE,    2, 8'h33, 1, 8'h00, 1, 2, 8'h33));
    tabla.push_back(mk(OP_ESCRIBE,    3, 8'h44, 1, 8'h00, 1, 3, 8'h44));
    tabla.push_back(mk(OP_LEE,        3, 8'h00, 2, 8'h44, 0, 0, 8'h00));
    tabla.push_back(mk(OP_LIMPIA,     2, 8'h99, 4, 8'h00, 4, 0, 8'h00));
    tabla.push_back(mk(OP_LEE,        0, 8'h00, 2, 8'h00, 0, 0, 8'h00));
    tabla.push_back(mk(OP_LEE,        1, 8'h00, 2, 8'h00, 0, 0, 8'h00));
    tabla.push_back(mk(OP_LEE,        2, 8'h00, 2, 8'h00, 0, 0, 8'h00));
    tabla.push_back(mk(OP_LEE,        3, 8'h00, 2, 8'h00, 0, 0, 8'h00));
    tabla.push_back(mk(OP_ESCRIBE,    3, 8'h7C, 1, 8'h00, 1, 3, 8'h7C));
    foreach (tabla[i]) run($sformatf("v%0d", i), tabla[i]);

    // Response stalled for 5 cycles while another command is offered.
    send(OP_LEE, 3, 8'h00);
    repeat (2) @(negedge clk);
    wr_log.delete();
    cmd_valid = 1'b1; cmd_op = OP_ESCRIBE; cmd_dir = 3; cmd_dato = 8'hEE;
    for (int i = 0; i < 5; i++) begin
      chk($sformatf("stall%0d", i), {22'd0, rsp_valid, cmd_ready, rsp_dato}, {22'd0, 2'b10, 8'h7C});
      @(negedge clk);
    end
    cmd_valid = 1'b0;
    rsp_ready = 1'b1;
    @(negedge clk);
    rsp_ready = 1'b0;
    chk("stall_release", {30'd0, rsp_valid, cmd_ready}, 32'b01);
    chk("stall_nowrite", 32'(wr_log.size()), 32'd0);
    run("stall_reread", mk(OP_LEE, 3, 8'h00, 2, 8'h7C, 0, 0, 8'h00));

    // Reset during the second clear write.
    run("pre0", mk(OP_ESCRIBE, 0, 8'h11, 1, 8'h00, 1, 0, 8'h11));
    run("pre1", mk(OP_ESCRIBE, 1, 8'h22, 1, 8'h00, 1, 1, 8'h22));
    run("pre2", mk(OP_ESCRIBE, 2, 8'h33, 1, 8'h00, 1, 2, 8'h33));
    run("pre3", mk(OP_ESCRIBE, 3, 8'h44, 1, 8'h00, 1, 3, 8'h44));
    send(OP_LIMPIA, 0, 8'h00);
    @(negedge clk);
    chk("clr_2nd_dir", {30'd0, Dir_br}, 32'd1);
    rst = 1'b1;
    @(negedge clk);
    chk("rst_mid_outs", {9'd0, En_br, WE_br, Dir_br, Dato_e_br, rsp_valid, rsp_dato, ocupado, cmd_ready},
        32'h0000_0001);
    rst = 1'b0;
    @(negedge clk);
    run("rst_r0", mk(OP_LEE, 0, 8'h00, 2, 8'h00, 0, 0, 8'h00));
    run("rst_r2", mk(OP_LEE, 2, 8'h00, 2, 8'h33, 0, 0, 8'h00));
    run("rst_r3", mk(OP_LEE, 3, 8'h00, 2, 8'h44, 0, 0, 8'h00));

    // Back-to-back writes with cmd_valid held high.
    wr_log.delete();
    acc = 0; pat = '0;
    cmd_valid = 1'b1; cmd_op = OP_ESCRIBE; cmd_dir = 0; cmd_dato = 8'h5A;
    for (int i = 0; i < 8; i++) begin
      pat[i] = cmd_ready;
      if (cmd_ready) acc++;
      @(negedge clk);
    end
    cmd_valid = 1'b0;
    chk("b2b_pattern", {24'd0, pat}, 32'h55);
    chk("b2b_accepts", 32'(acc), 32'd4);
    chk("b2b_writes", 32'(wr_log.size()), 32'd4);
    @(negedge clk);
    chk("ready_vs_busy", 32'(viol), 32'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
